// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared types for the multi-cycle execute stage.
//   DATA_WIDTH      operand / result width
//   aluop_t         single-cycle ALU operations
//   mdop_t          RV32M multiply / divide operations (MD_NONE selects the ALU path)
//   ex_mc_state_t   execute-stage control states
//   ex_stage_in_t   decode -> execute payload
//   ex_stage_out_t  execute -> memory payload
package ex_stage_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } aluop_t;

    typedef enum logic [3:0] {
        MD_NONE, MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
        MD_DIV,  MD_DIVU, MD_REM, MD_REMU
    } mdop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIN  = 2'd2
    } ex_mc_state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] opr_a;
        logic [DATA_WIDTH-1:0] opr_b;
        logic [DATA_WIDTH-1:0] imm;
        logic                  opr_b_sel;
        aluop_t                aluop;
        mdop_t                 mdop;
        logic [4:0]            rd;
        logic                  rf_en;
        logic                  dm_en;
        logic [1:0]            wb_sel;
        logic [2:0]            lsuop;
    } ex_stage_in_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] opr_res;
        logic [DATA_WIDTH-1:0] opr_b;
        logic [4:0]            rd;
        logic                  rf_en;
        logic                  dm_en;
        logic [1:0]            wb_sel;
        logic [2:0]            lsuop;
    } ex_stage_out_t;

    function automatic logic is_div_op(mdop_t op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational single-cycle integer ALU.
//   opr_a, opr_b  operands
//   aluop         operation select
//   opr_res       result
module alu
    import ex_stage_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] opr_a,
    input  logic [DATA_WIDTH-1:0] opr_b,
    input  aluop_t                aluop,
    output logic [DATA_WIDTH-1:0] opr_res
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt = opr_b[SHW-1:0];

    always_comb begin
        opr_res = '0;
        case (aluop)
            ALU_ADD:  opr_res = opr_a + opr_b;
            ALU_SUB:  opr_res = opr_a - opr_b;
            ALU_SLL:  opr_res = opr_a << shamt;
            ALU_SLT:  opr_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(opr_a) < $signed(opr_b))};
            ALU_SLTU: opr_res = {{(DATA_WIDTH-1){1'b0}}, (opr_a < opr_b)};
            ALU_XOR:  opr_res = opr_a ^ opr_b;
            ALU_SRL:  opr_res = opr_a >> shamt;
            ALU_SRA:  opr_res = $unsigned($signed(opr_a) >>> shamt);
            ALU_OR:   opr_res = opr_a | opr_b;
            ALU_AND:  opr_res = opr_a & opr_b;
            default:  opr_res = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage_mc_muldiv.sv
// muldiv_iter: iterative radix-2 unsigned multiplier / restoring divider.
//   start          load operands and clear the counter (has priority over step)
//   step           perform one iteration
//   is_div         mode latched at start: 1 = divide, 0 = multiply
//   opr_a, opr_b   multiplier / multiplicand, or dividend / divisor (magnitudes)
//   done           counter is on the last iteration
//   res_hi, res_lo product {hi,lo}, or remainder (hi) and quotient (lo)
module muldiv_iter
    import ex_stage_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] opr_a,
    input  logic [W-1:0] opr_b,
    output logic         done,
    output logic [W-1:0] res_hi,
    output logic [W-1:0] res_lo
);

    localparam int CW = $clog2(W);

    logic [CW-1:0] cnt;
    logic [W-1:0]  hi, lo, operand;
    logic          div_mode;
    logic [W:0]    add_sum, trial;
    logic [W-1:0]  nxt_hi, nxt_lo;

    // hi/lo form one 2W shift register for both modes.
    // Multiply: add multiplicand into hi when lo[0] is set, then shift right.
    // Divide: shift left one dividend bit into hi, subtract divisor if it fits.
    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(W+1){1'b0}});
        trial   = {hi, lo[W-1]} - {1'b0, operand};
        if (div_mode) begin
            // trial[W] is the borrow: set means the divisor did not fit
            if (!trial[W]) begin
                nxt_hi = trial[W-1:0];
                nxt_lo = {lo[W-2:0], 1'b1};
            end else begin
                nxt_hi = {hi[W-2:0], lo[W-1]};
                nxt_lo = {lo[W-2:0], 1'b0};
            end
        end else begin
            nxt_hi = add_sum[W:1];
            nxt_lo = {add_sum[0], lo[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            operand  <= '0;
            div_mode <= 1'b0;
        end else if (start) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= opr_a;
            operand  <= opr_b;
            div_mode <= is_div;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            hi  <= nxt_hi;
            lo  <= nxt_lo;
        end
    end

    assign done   = (cnt == CW'(W-1));
    assign res_hi = hi;
    assign res_lo = lo;

endmodule

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with single-cycle ALU and multi-cycle RV32M unit.
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         kills in-flight mul/div and the output slot
//   in_valid/in_ready, ex_stage_in     upstream handshake and payload
//   out_valid/out_ready, ex_stage_out  downstream handshake and registered payload
//   state_dbg     current control state (ex_mc_state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the sender holds payload stable while valid && !ready, and ready never
// depends on valid.
module ex_stage_mc
    import ex_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  ex_stage_in_t  ex_stage_in,
    output logic          out_valid,
    input  logic          out_ready,
    output ex_stage_out_t ex_stage_out,
    output logic [1:0]    state_dbg
);

    localparam int W = DATA_WIDTH;

    ex_mc_state_t  state;
    logic          slot_free, accept, md_start, md_step, md_done;
    logic [W-1:0]  alu_b, alu_res, md_hi, md_lo;
    logic          a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0]  a_mag, b_mag;

    // Latched at mul/div accept
    mdop_t         md_op;
    logic          a_neg_q, b_neg_q, div_zero_q;
    logic [W-1:0]  dividend_q;
    ex_stage_out_t pend;

    logic [2*W-1:0] prod_raw, prod_fix;
    logic [W-1:0]   quot_fix, rem_fix, md_res;
    ex_stage_out_t  alu_out, fin_out;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == ST_IDLE) && !flush && slot_free;
    assign accept    = in_valid && in_ready;
    assign md_start  = accept && (ex_stage_in.mdop != MD_NONE);
    assign md_step   = (state == ST_BUSY) && !flush;
    assign state_dbg = state;

    assign alu_b = ex_stage_in.opr_b_sel ? ex_stage_in.imm : ex_stage_in.opr_b;

    alu u_alu (
        .opr_a   (ex_stage_in.opr_a),
        .opr_b   (alu_b),
        .aluop   (ex_stage_in.aluop),
        .opr_res (alu_res)
    );

    // Operand signedness per op; the iterative unit only sees magnitudes.
    // MUL's low half is sign-independent, so it runs unsigned.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (ex_stage_in.mdop)
            MD_MULH, MD_DIV, MD_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            MD_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        a_neg = a_signed && ex_stage_in.opr_a[W-1];
        b_neg = b_signed && ex_stage_in.opr_b[W-1];
        a_mag = a_neg ? -ex_stage_in.opr_a : ex_stage_in.opr_a;
        b_mag = b_neg ? -ex_stage_in.opr_b : ex_stage_in.opr_b;
    end

    muldiv_iter #(.W(W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .step   (md_step),
        .is_div (is_div_op(ex_stage_in.mdop)),
        .opr_a  (a_mag),
        .opr_b  (b_mag),
        .done   (md_done),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    // Sign correction and result select, used in FIN.
    // Most-negative / -1 needs no special case: the magnitude quotient 2^(W-1)
    // negates back to most-negative and the remainder is zero.
    always_comb begin
        prod_raw = {md_hi, md_lo};
        prod_fix = (a_neg_q ^ b_neg_q) ? -prod_raw : prod_raw;
        quot_fix = (a_neg_q ^ b_neg_q) ? -md_lo : md_lo;
        rem_fix  = a_neg_q ? -md_hi : md_hi;
        md_res   = '0;
        case (md_op)
            MD_MUL:                       md_res = md_lo;
            MD_MULH, MD_MULHSU, MD_MULHU: md_res = prod_fix[2*W-1:W];
            MD_DIV, MD_DIVU:              md_res = div_zero_q ? '1 : quot_fix;
            MD_REM, MD_REMU:              md_res = div_zero_q ? dividend_q : rem_fix;
            default:                      md_res = '0;
        endcase
    end

    always_comb begin
        alu_out.opr_res = alu_res;
        alu_out.opr_b   = ex_stage_in.opr_b;
        alu_out.rd      = ex_stage_in.rd;
        alu_out.rf_en   = ex_stage_in.rf_en;
        alu_out.dm_en   = ex_stage_in.dm_en;
        alu_out.wb_sel  = ex_stage_in.wb_sel;
        alu_out.lsuop   = ex_stage_in.lsuop;
        fin_out         = pend;
        fin_out.opr_res = md_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            ex_stage_out <= '0;
            md_op        <= MD_NONE;
            a_neg_q      <= 1'b0;
            b_neg_q      <= 1'b0;
            div_zero_q   <= 1'b0;
            dividend_q   <= '0;
            pend         <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            // Consume; a load below in the same cycle overrides this.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (ex_stage_in.mdop == MD_NONE) begin
                            ex_stage_out <= alu_out;
                            out_valid    <= 1'b1;
                        end else begin
                            md_op      <= ex_stage_in.mdop;
                            a_neg_q    <= a_neg;
                            b_neg_q    <= b_neg;
                            div_zero_q <= (ex_stage_in.opr_b == '0);
                            dividend_q <= ex_stage_in.opr_a;
                            pend       <= alu_out;
                            state      <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    if (slot_free) begin
                        ex_stage_out <= fin_out;
                        out_valid    <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Multi-cycle execute stage adding the RV32M multiply/divide operations to the single-cycle ALU path. It sits between decode and memory with a valid/ready handshake on both sides. ALU operations complete in one cycle. MUL/DIV operations run on an iterative radix-2 unit for a fixed latency while the stage back-pressures upstream. Results and pass-through control fields leave through one registered output slot.

## Interface
- DATA_WIDTH, 32, operand/result width (even, ≥8)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of in-flight and output-slot work
- in_valid  in  1  ex_stage_in holds a valid instruction
- in_ready  out  1  stage accepts this cycle
- ex_stage_in  in  ex_stage_in_t  operands, imm, opr_b_sel, aluop, mdop, rd, rf_en, dm_en, wb_sel, lsuop
- out_valid  out  1  ex_stage_out valid
- out_ready  in  1  downstream consumes this cycle
- ex_stage_out  out  ex_stage_out_t  opr_res, opr_b, rd, rf_en, dm_en, wb_sel, lsuop

## Operation
- States: IDLE, BUSY, FIN.
- Reset: state IDLE, out_valid 0, ex_stage_out all zero, counter 0.
- in_ready = (state==IDLE) && !flush && (!out_valid || out_ready). This is combinational.
- Accept (in_valid && in_ready):
  - Pass-through fields are always captured. opr_b is the raw register operand, not the imm-muxed value.
  - mdop==MD_NONE: opr_b operand = opr_b_sel ? imm : opr_b. The ALU result is loaded into the output slot and out_valid is set.
  - Otherwise: operand magnitudes and sign flags are latched, counter cleared, and the state goes to BUSY.
- BUSY: one product/quotient bit per cycle. After DATA_WIDTH iterations (counter==DATA_WIDTH-1) the state goes to FIN.
- FIN: sign correction and result select are applied. When !out_valid || out_ready, the result loads into the slot, out_valid is set, and the state goes to IDLE. Otherwise FIN holds.
- Output slot: out_valid clears on out_ready when no new load occurs. Load and consume in the same cycle replaces the slot contents.
- Ops and results:
  - MUL: low half of product.
  - MULH / MULHSU / MULHU: high half, signed×signed / signed×unsigned / unsigned×unsigned.
  - DIV / DIVU / REM / REMU: per RISC-V M.
- Divide by zero: quotient = all ones, remainder = dividend. Detected at accept, forced in FIN. Full latency is still taken.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0. This falls out of magnitude division plus negation and is checked in test.
- Remainder takes the dividend's sign. Quotient is negated when signs differ.
- flush: state goes to IDLE, out_valid goes to 0, and the iterative unit is abandoned. flush has priority over accept, FIN load and consume.

## Timing
- ALU op accepted at edge N: out_valid high after edge N, so throughput is one per cycle when out_ready=1.
- MUL/DIV accepted at edge N: BUSY spans edges N+1..N+DATA_WIDTH, FIN at N+DATA_WIDTH+1, out_valid high after that edge. Total latency is DATA_WIDTH+1 edges when the slot is free.
- in_ready is low from acceptance of a MUL/DIV until FIN loads. The earliest next accept is the FIN-load cycle + 1.
- Back-pressure: out_valid && !out_ready holds ex_stage_out stable and keeps in_ready low.
- Reset asserted mid-operation: immediate return to reset values. No partial result is emitted.

## Structure
- ex_stage_pkg adds:
  - mdop_t enum: MD_NONE, MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU.
  - mdop field in ex_stage_in_t.
  - ex_mc_state_t enum.
- Sub-modules:
  - Existing alu, instantiated unchanged.
  - muldiv_iter: iterative shift-add multiplier / restoring divider with start, busy counter and raw results. Sign handling stays in ex_stage_mc.

## Test plan
- ADD 5+7, then SUB 3-10 back-to-back, out_ready=1 → results 12 then 0xFFFFFFF9 on consecutive cycles, in_ready constantly 1.
- MULH 0x80000000×0x80000000 → 0x40000000 after 33 edges. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF. MULHU same operands → 0x00000001. in_ready low throughout.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0. DIV -7/2 → -3, REM → -1. DIVU 7/0 → 0xFFFFFFFF, REMU 7/0 → 7.
- MUL result in FIN with out_ready=0 for 5 cycles → FIN holds, prior slot data stable, load one cycle after out_ready rises.
- flush at BUSY counter 10, with in_valid high that cycle → next cycle IDLE, out_valid 0, the in_valid instruction not accepted, the following ADD completes normally.
- rst_n low mid-DIV, then release → all outputs zero, in_ready 1, no stale result ever appears.
